// File: rtl/debug_capture.sv
// Trigger-based capture buffer: records valid samples into a BRAM ring around a trigger, then reads out oldest-first.
// Optional value-match trigger enabled by defining DEBUG_CAPTURE_VALUE_TRIG_EN.
module debug_capture #(
    parameter int unsigned DWIDTH     = 24,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned PRETRIG    = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  data_in_valid,
    input  logic [DWIDTH-1:0]     data_in,
    input  logic                  arm,
    input  logic                  trigger,
    input  logic                  rd_next,
    input  logic                  rd_rewind,
`ifdef DEBUG_CAPTURE_VALUE_TRIG_EN
    input  logic [DWIDTH-1:0]     trig_mask,
    input  logic [DWIDTH-1:0]     trig_value,
`endif
    output logic [DWIDTH-1:0]     data_out,
    output logic                  armed,
    output logic                  triggered,
    output logic                  done,
    output logic [DEPTH_LOG2-1:0] trig_addr
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]         PRE_LEN   = CW'(PRETRIG);
    localparam logic [CW-1:0]         POST_LEN  = CW'(DEPTH - PRETRIG);
    localparam logic [DEPTH_LOG2-1:0] PRE_OFFS  = DEPTH_LOG2'(PRETRIG);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  arm_q, trig_q, rdn_q;
    logic                  trig_pend_q, trig_pend_d;
    logic [DEPTH_LOG2-1:0] wr_addr_q, wr_addr_d;
    logic [DEPTH_LOG2-1:0] trig_addr_q, trig_addr_d;
    logic [DEPTH_LOG2-1:0] rd_idx_q, rd_idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DWIDTH-1:0]     data_out_q;

    logic                  arm_edge, trig_edge, rdn_edge;
    logic                  value_hit;
    logic                  wr_en;
    logic [CW-1:0]         cnt_inc;
    logic [DEPTH_LOG2-1:0] rd_addr;

    logic [DWIDTH-1:0]     mem [DEPTH];

    assign arm_edge  = arm && !arm_q;
    assign trig_edge = trigger && !trig_q;
    assign rdn_edge  = rd_next && !rdn_q;
    assign cnt_inc   = cnt_q + 1'b1;

`ifdef DEBUG_CAPTURE_VALUE_TRIG_EN
    // An all-zero mask would match every sample, so it disables value matching.
    assign value_hit = (|trig_mask) &&
                       ((data_in & trig_mask) == (trig_value & trig_mask));
`else
    assign value_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            arm_q       <= 1'b0;
            trig_q      <= 1'b0;
            rdn_q       <= 1'b0;
            trig_pend_q <= 1'b0;
            wr_addr_q   <= '0;
            trig_addr_q <= '0;
            rd_idx_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            arm_q       <= arm;
            trig_q      <= trigger;
            rdn_q       <= rd_next;
            trig_pend_q <= trig_pend_d;
            wr_addr_q   <= wr_addr_d;
            trig_addr_q <= trig_addr_d;
            rd_idx_q    <= rd_idx_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        trig_pend_d = trig_pend_q;
        wr_addr_d   = wr_addr_q;
        trig_addr_d = trig_addr_q;
        rd_idx_d    = rd_idx_q;
        cnt_d       = cnt_q;
        wr_en       = 1'b0;

        if (arm_edge) begin
            state_d     = (PRETRIG == 0) ? S_WAIT : S_PRE;
            wr_addr_d   = '0;
            trig_pend_d = 1'b0;
            cnt_d       = '0;
        end else begin
            case (state_q)
                S_PRE: begin
                    if (data_in_valid) begin
                        wr_en     = 1'b1;
                        wr_addr_d = wr_addr_q + 1'b1;
                        cnt_d     = cnt_inc;
                        if (cnt_inc == PRE_LEN) begin
                            state_d = S_WAIT;
                            cnt_d   = '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (data_in_valid) begin
                        wr_en     = 1'b1;
                        wr_addr_d = wr_addr_q + 1'b1;
                        // The sample written this cycle is the trigger sample and counts as the first POST sample.
                        if (trig_pend_q || trig_edge || value_hit) begin
                            trig_addr_d = wr_addr_q;
                            trig_pend_d = 1'b0;
                            cnt_d       = CW'(1);
                            state_d     = (POST_LEN == CW'(1)) ? S_DONE : S_POST;
                        end
                    end else if (trig_edge) begin
                        trig_pend_d = 1'b1;
                    end
                end
                S_POST: begin
                    if (data_in_valid) begin
                        wr_en     = 1'b1;
                        wr_addr_d = wr_addr_q + 1'b1;
                        cnt_d     = cnt_inc;
                        if (cnt_inc == POST_LEN) state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (rdn_edge) rd_idx_d = rd_idx_q + 1'b1;
                end
                default: ;
            endcase
        end

        if (rd_rewind || (state_d == S_DONE && state_q != S_DONE)) rd_idx_d = '0;

        armed     = (state_q == S_PRE) || (state_q == S_WAIT);
        triggered = (state_q == S_POST);
        done      = (state_q == S_DONE);
    end

    assign rd_addr = trig_addr_q - PRE_OFFS + rd_idx_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr_q] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) data_out_q <= '0;
        else       data_out_q <= mem[rd_addr];
    end

    assign data_out  = data_out_q;
    assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_debug_capture.sv
// Directed bench for debug_capture (DWIDTH=8, DEPTH_LOG2=4, PRETRIG=4); data_in is a running sample count.
module tb_debug_capture;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data_in_valid = 1'b0;
    logic [7:0] data_in = '0;
    logic       arm = 1'b0;
    logic       trigger = 1'b0;
    logic       rd_next = 1'b0;
    logic       rd_rewind = 1'b0;
`ifdef DEBUG_CAPTURE_VALUE_TRIG_EN
    logic [7:0] trig_mask = '0;
    logic [7:0] trig_value = '0;
`endif
    logic [7:0] data_out;
    logic       armed, triggered, done;
    logic [3:0] trig_addr;

    int n_checks = 0;
    int n_fail   = 0;

    debug_capture #(.DWIDTH(8), .DEPTH_LOG2(4), .PRETRIG(4)) dut (
        .clk(clk), .reset(reset), .data_in_valid(data_in_valid), .data_in(data_in),
        .arm(arm), .trigger(trigger), .rd_next(rd_next), .rd_rewind(rd_rewind),
`ifdef DEBUG_CAPTURE_VALUE_TRIG_EN
        .trig_mask(trig_mask), .trig_value(trig_value),
`endif
        .data_out(data_out), .armed(armed), .triggered(triggered), .done(done),
        .trig_addr(trig_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_arm();
        trigger = 1'b0;
        data_in_valid = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("armed_after_arm", {31'd0, armed}, 32'd1);
    endtask

    // Reads all 16 entries expecting first, first+stride, ...; 16 rd_next edges wrap back to the oldest.
    task automatic read_check(input int first, input int stride);
        tick();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("read[%0d]", i), {24'd0, data_out}, 32'((first + stride * i) & 8'hFF));
            rd_next = 1'b1;
            tick();
            if (i == 0) check("read_latency_hold", {24'd0, data_out}, 32'(first & 8'hFF));
            rd_next = 1'b0;
            tick();
        end
        check("read_wrap", {24'd0, data_out}, 32'(first & 8'hFF));
    endtask

    // Arms, feeds 0,1,2.. every cycle, triggers at trig_at (optionally also pulses trigger in PRE).
    task automatic run_capture(input int trig_at, input int pre_trig_at);
        do_arm();
        for (int s = 0; s <= trig_at + 11; s++) begin
            data_in = 8'(s);
            data_in_valid = 1'b1;
            trigger = (s == trig_at) || (s == pre_trig_at);
            tick();
            if (s == pre_trig_at) begin
                check("pre_trig_ignored_armed", {31'd0, armed}, 32'd1);
                check("pre_trig_ignored_trig", {31'd0, triggered}, 32'd0);
            end
            if (s == trig_at)      check("triggered_on_trig", {31'd0, triggered}, 32'd1);
            if (s == trig_at + 10) check("done_not_early", {31'd0, done}, 32'd0);
        end
        trigger = 1'b0;
        check("done_after_post", {31'd0, done}, 32'd1);
        check("trig_addr", {28'd0, trig_addr}, 32'(trig_at % 16));
    endtask

    initial begin
        repeat (3) tick();
        check("rst_armed", {31'd0, armed}, 32'd0);
        check("rst_triggered", {31'd0, triggered}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_trig_addr", {28'd0, trig_addr}, 32'd0);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        reset = 1'b0;
        tick();

        // Basic capture: trigger at sample 20 -> readout 16..31.
        run_capture(20, -1);
        read_check(16, 1);
        rd_next = 1'b1; tick(); rd_next = 1'b0; tick();
        check("read_17th_step", {24'd0, data_out}, 32'd17);
        rd_rewind = 1'b1; rd_next = 1'b1; tick();
        rd_rewind = 1'b0; rd_next = 1'b0; tick();
        check("rewind_overrides_next", {24'd0, data_out}, 32'd16);

        // Trigger pulsed during PRE is ignored; later trigger at 10 -> readout 6..21.
        run_capture(10, 1);
        read_check(6, 1);

        // Valid 1-of-3; trigger edge at an invalid cycle becomes pending.
        do_arm();
        for (int c = 0; c <= 66; c++) begin
            data_in = 8'(c);
            data_in_valid = (c % 3 == 0);
            trigger = (c == 31);
            tick();
            if (c == 32) begin
                check("pend_still_wait", {31'd0, armed}, 32'd1);
                check("pend_not_triggered", {31'd0, triggered}, 32'd0);
            end
            if (c == 33) check("pend_triggered", {31'd0, triggered}, 32'd1);
            if (c == 65) check("sparse_done_not_early", {31'd0, done}, 32'd0);
        end
        trigger = 1'b0;
        check("sparse_done", {31'd0, done}, 32'd1);
        check("sparse_trig_addr", {28'd0, trig_addr}, 32'd11);
        read_check(21, 3);

        // Reset during POST, then a fresh capture.
        do_arm();
        for (int s = 0; s <= 12; s++) begin
            data_in = 8'(s);
            data_in_valid = 1'b1;
            trigger = (s == 8);
            tick();
        end
        trigger = 1'b0;
        check("in_post_before_reset", {31'd0, triggered}, 32'd1);
        reset = 1'b1;
        tick();
        check("mid_rst_armed", {31'd0, armed}, 32'd0);
        check("mid_rst_triggered", {31'd0, triggered}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_trig_addr", {28'd0, trig_addr}, 32'd0);
        check("mid_rst_data_out", {24'd0, data_out}, 32'd0);
        reset = 1'b0;
        tick();
        run_capture(13, -1);
        read_check(9, 1);

`ifdef DEBUG_CAPTURE_VALUE_TRIG_EN
        // Value match on sample 40 with no external trigger -> readout 36..51.
        trig_mask = 8'hFF;
        trig_value = 8'd40;
        do_arm();
        for (int s = 0; s <= 51; s++) begin
            data_in = 8'(s);
            data_in_valid = 1'b1;
            tick();
            if (s == 40) check("value_triggered", {31'd0, triggered}, 32'd1);
        end
        check("value_done", {31'd0, done}, 32'd1);
        check("value_trig_addr", {28'd0, trig_addr}, 32'd8);
        read_check(36, 1);
        trig_mask = '0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
